// File: rtl/load_store_unit.sv
// Load/store unit: turns datapath load/store requests into a single-word
// valid/ready bus transaction, formats load results, stalls the datapath
// while the access is in flight, and flags misaligned/illegal accesses and
// bus timeouts.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for a request; decode and launch or flag misalign
// ACCESS | bus_valid high, waiting for bus_ready (bounded by TIMEOUT)
// DONE   | transfer complete, stall released, datapath advances
// ERR    | bus timed out, bus_fault pulse, stall released
module load_store_unit #(
    parameter int AW      = 14,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_rd,
    input  logic          req_wr,
    input  logic [2:0]    f3,
    input  logic [31:0]   addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   read_data,
    output logic          stall,
    output logic          misalign,
    output logic          bus_fault,
    output logic          bus_valid,
    output logic          bus_we,
    output logic [AW-1:0] bus_addr,
    output logic [3:0]    bus_be,
    output logic [31:0]   bus_wdata,
    input  logic          bus_ready,
    input  logic [31:0]   bus_rdata
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2,
        S_ERR    = 2'd3
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_f3;
    logic [1:0]    r_off;
    logic [31:0]   r_read_data;
    logic          r_bus_fault;
    logic          r_bus_valid;
    logic          r_bus_we;
    logic [AW-1:0] r_bus_addr;
    logic [3:0]    r_bus_be;
    logic [31:0]   r_bus_wdata;

    logic          w_req;
    logic          w_legal;
    logic          w_aligned;
    logic          w_go;
    logic          w_bad;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata;
    logic [31:0]   w_load_fmt;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [31:0]   w_shifted;
    logic          w_unused;

    // Upper address bits beyond the 16-bit byte space are not decoded.
    assign w_unused = &{1'b0, addr[31:AW+2]};

    assign w_req = req_rd | req_wr;

    // Decode legality of f3 (a simultaneous read+write is a store) and alignment.
    always_comb begin
        w_legal = 1'b0;
        if (req_wr) begin
            w_legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
        end else begin
            w_legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                      (f3 == 3'b100) || (f3 == 3'b101);
        end
        case (f3[1:0])
            2'b01:   w_aligned = ~addr[0];
            2'b10:   w_aligned = (addr[1:0] == 2'b00);
            default: w_aligned = 1'b1;
        endcase
    end

    assign w_go  = (r_state == S_IDLE) && w_req &&  (w_legal && w_aligned);
    assign w_bad = (r_state == S_IDLE) && w_req && !(w_legal && w_aligned);

    // Stall and misalign respond in the request cycle itself, so they are
    // combinational; both are forced low while reset is asserted.
    assign stall    = rst_n & (w_go | (r_state == S_ACCESS));
    assign misalign = rst_n & w_bad;

    // Byte enables and lane-replicated store data for the launching request.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = wdata;
        if (req_wr) begin
            case (f3[1:0])
                2'b00: begin
                    w_be    = 4'b0001 << addr[1:0];
                    w_wdata = {4{wdata[7:0]}};
                end
                2'b01: begin
                    w_be    = addr[1] ? 4'b1100 : 4'b0011;
                    w_wdata = {2{wdata[15:0]}};
                end
                default: begin
                    w_be    = 4'b1111;
                    w_wdata = wdata;
                end
            endcase
        end
    end

    // Lane select and sign/zero extension of the returned read word.
    always_comb begin
        w_shifted  = bus_rdata >> {r_off, 3'b000};
        w_byte     = w_shifted[7:0];
        w_half     = r_off[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (r_f3)
            3'b000:  w_load_fmt = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_fmt = {{16{w_half[15]}}, w_half};
            3'b100:  w_load_fmt = {24'd0, w_byte};
            3'b101:  w_load_fmt = {16'd0, w_half};
            default: w_load_fmt = bus_rdata;
        endcase
    end

    // Transaction FSM with registered bus outputs, load result and fault pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_f3        <= 3'b000;
            r_off       <= 2'b00;
            r_read_data <= 32'd0;
            r_bus_fault <= 1'b0;
            r_bus_valid <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_be    <= 4'b0000;
            r_bus_wdata <= 32'd0;
        end else begin
            r_bus_fault <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_go) begin
                        r_state     <= S_ACCESS;
                        r_cnt       <= '0;
                        r_f3        <= f3;
                        r_off       <= addr[1:0];
                        r_bus_valid <= 1'b1;
                        r_bus_we    <= req_wr;
                        r_bus_addr  <= addr[AW+1:2];
                        r_bus_be    <= w_be;
                        r_bus_wdata <= w_wdata;
                    end
                end
                S_ACCESS: begin
                    if (bus_ready) begin
                        if (!r_bus_we) begin
                            r_read_data <= w_load_fmt;
                        end
                        r_bus_valid <= 1'b0;
                        r_cnt       <= '0;
                        r_state     <= S_DONE;
                    end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                        if (!r_bus_we) begin
                            r_read_data <= 32'd0;
                        end
                        r_bus_valid <= 1'b0;
                        r_bus_fault <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= S_ERR;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                S_ERR:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign read_data = r_read_data;
    assign bus_fault = r_bus_fault;
    assign bus_valid = r_bus_valid;
    assign bus_we    = r_bus_we;
    assign bus_addr  = r_bus_addr;
    assign bus_be    = r_bus_be;
    assign bus_wdata = r_bus_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: directed cases followed by randomized
// transactions, each checked against a reference model of the access rules.
module tb_load_store_unit;

    localparam int AW      = 14;
    localparam int TIMEOUT = 15;

    logic          clk;
    logic          rst_n;
    logic          req_rd;
    logic          req_wr;
    logic [2:0]    f3;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic [31:0]   read_data;
    logic          stall;
    logic          misalign;
    logic          bus_fault;
    logic          bus_valid;
    logic          bus_we;
    logic [AW-1:0] bus_addr;
    logic [3:0]    bus_be;
    logic [31:0]   bus_wdata;
    logic          bus_ready;
    logic [31:0]   bus_rdata;

    int            tests = 0;
    int            fails = 0;
    logic [31:0]   exp_rd = 32'd0;

    load_store_unit #(.AW(AW), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_rd    (req_rd),
        .req_wr    (req_wr),
        .f3        (f3),
        .addr      (addr),
        .wdata     (wdata),
        .read_data (read_data),
        .stall     (stall),
        .misalign  (misalign),
        .bus_fault (bus_fault),
        .bus_valid (bus_valid),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_be    (bus_be),
        .bus_wdata (bus_wdata),
        .bus_ready (bus_ready),
        .bus_rdata (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: formatted load value from the size/sign rules.
    function automatic logic [31:0] model_load(input logic [2:0] f, input logic [31:0] a,
                                               input logic [31:0] w);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * (a % 4))) % 256;
        h = (w >> (16 * ((a % 4) / 2))) % 65536;
        case (f)
            3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    // One complete request. Entered and left at posedge+1.
    // waitc = cycles with bus_ready low before it rises; >= TIMEOUT means never.
    task automatic access(input logic rd, input logic wr, input logic [2:0] f,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rdat, input int waitc);
        logic        legal;
        logic        ok;
        logic [3:0]  e_be;
        logic [31:0] e_wd;
        int          e_n;
        int          off;
        off = int'(a % 4);
        if (wr) legal = (f <= 3'd2);
        else    legal = (f <= 3'd2) || (f == 3'd4) || (f == 3'd5);
        ok = legal && !((f % 4 == 1) && (off % 2 != 0)) && !((f % 4 == 2) && (off != 0));
        e_be = 4'hF;
        e_wd = wd;
        if (wr && f == 3'd0) begin
            e_be = 4'(1 << off);
            e_wd = (wd % 256) * 32'h0101_0101;
        end else if (wr && f == 3'd1) begin
            e_be = 4'(3 << (off / 2 * 2));
            e_wd = (wd % 65536) * 32'h0001_0001;
        end
        req_rd    = rd;
        req_wr    = wr;
        f3        = f;
        addr      = a;
        wdata     = wd;
        bus_rdata = rdat;
        bus_ready = 1'($urandom % 2);
        @(negedge clk);
        if (!ok) begin
            chk("misalign_pulse", 32'(misalign), 32'd1);
            chk("misalign_stall", 32'(stall), 32'd0);
            chk("misalign_valid", 32'(bus_valid), 32'd0);
            @(posedge clk); #1;
            req_rd = 1'b0; req_wr = 1'b0; bus_ready = 1'b0;
            @(negedge clk);
            chk("misalign_end", 32'(misalign), 32'd0);
            chk("misalign_valid2", 32'(bus_valid), 32'd0);
            chk("misalign_rd_hold", read_data, exp_rd);
            @(posedge clk); #1;
            return;
        end
        chk("req_stall", 32'(stall), 32'd1);
        chk("req_misalign", 32'(misalign), 32'd0);
        chk("req_valid", 32'(bus_valid), 32'd0);
        @(posedge clk); #1;
        e_n = (waitc < TIMEOUT) ? waitc + 1 : TIMEOUT;
        for (int k = 0; k < e_n; k++) begin
            bus_ready = (k == waitc);
            bus_rdata = (k == waitc) ? rdat : $urandom;
            @(negedge clk);
            chk("acc_valid", 32'(bus_valid), 32'd1);
            chk("acc_stall", 32'(stall), 32'd1);
            chk("acc_addr", 32'(bus_addr), (a >> 2) % (1 << AW));
            chk("acc_be", 32'(bus_be), 32'(e_be));
            chk("acc_we", 32'(bus_we), 32'(wr));
            if (wr) chk("acc_wdata", bus_wdata, e_wd);
            @(posedge clk); #1;
        end
        if (!wr) exp_rd = (waitc < TIMEOUT) ? model_load(f, a, rdat) : 32'd0;
        bus_ready = 1'($urandom % 2);
        bus_rdata = $urandom;
        @(negedge clk);
        chk("end_valid", 32'(bus_valid), 32'd0);
        chk("end_stall", 32'(stall), 32'd0);
        chk("end_fault", 32'(bus_fault), (waitc < TIMEOUT) ? 32'd0 : 32'd1);
        chk("end_read_data", read_data, exp_rd);
        @(posedge clk); #1;
        req_rd = 1'b0; req_wr = 1'b0; bus_ready = 1'b0;
        @(negedge clk);
        chk("idle_fault", 32'(bus_fault), 32'd0);
        chk("idle_valid", 32'(bus_valid), 32'd0);
        chk("idle_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0; req_rd = 1'b0; req_wr = 1'b0; f3 = 3'd0;
        addr = 32'd0; wdata = 32'd0; bus_ready = 1'b0; bus_rdata = 32'd0;
        @(negedge clk);
        chk("rst_read_data", read_data, 32'd0);
        chk("rst_valid", 32'(bus_valid), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_fault", 32'(bus_fault), 32'd0);
        chk("rst_be", 32'(bus_be), 32'd0);
        chk("rst_we", 32'(bus_we), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Idle with bus_ready toggling must do nothing.
        bus_ready = 1'b1;
        @(negedge clk);
        chk("idle_ready_valid", 32'(bus_valid), 32'd0);
        chk("idle_ready_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        bus_ready = 1'b0;

        access(1, 0, 3'd2, 32'h0000_0010, 32'd0, 32'hDEAD_BEEF, 0);
        chk("lw_value", read_data, 32'hDEAD_BEEF);
        access(1, 0, 3'd0, 32'h0000_0013, 32'd0, 32'h80FF_FFFF, 1);
        chk("lb_value", read_data, 32'hFFFF_FF80);
        access(1, 0, 3'd4, 32'h0000_0013, 32'd0, 32'h80FF_FFFF, 0);
        chk("lbu_value", read_data, 32'h0000_0080);
        access(1, 0, 3'd5, 32'h0000_0012, 32'd0, 32'hBEEF_1234, 2);
        chk("lhu_value", read_data, 32'h0000_BEEF);
        access(0, 1, 3'd0, 32'h0000_0021, 32'h0000_00AB, 32'h5555_5555, 0);
        access(0, 1, 3'd1, 32'h0000_0022, 32'h0000_1234, 32'h5555_5555, 1);
        chk("store_rd_hold", read_data, 32'h0000_BEEF);
        access(1, 0, 3'd1, 32'h0000_0011, 32'd0, 32'd0, 0);
        access(0, 1, 3'd2, 32'h0000_0022, 32'h1111_2222, 32'd0, 0);
        access(1, 0, 3'd3, 32'h0000_0020, 32'd0, 32'd0, 0);
        access(1, 1, 3'd2, 32'h0000_0044, 32'hCAFE_F00D, 32'h0, 0);
        access(1, 0, 3'd2, 32'h0000_0030, 32'd0, 32'h1234_5678, 100);
        chk("timeout_rd_zero", read_data, 32'd0);
        access(1, 0, 3'd2, 32'h0000_0034, 32'd0, 32'hA5A5_5A5A, 0);
        access(1, 0, 3'd2, 32'h0000_0038, 32'd0, 32'h0F0F_0F0F, TIMEOUT - 1);

        // Asynchronous reset in the middle of an access.
        req_rd = 1'b1; req_wr = 1'b0; f3 = 3'd2; addr = 32'h0000_0040; bus_ready = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("pre_rst_valid", 32'(bus_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(bus_valid), 32'd0);
        chk("async_rst_stall", 32'(stall), 32'd0);
        chk("async_rst_rd", read_data, 32'd0);
        exp_rd = 32'd0;
        @(posedge clk); #1;
        req_rd = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        access(1, 0, 3'd1, 32'h0000_0042, 32'd0, 32'h8001_7FFF, 0);
        chk("post_rst_lh", read_data, 32'hFFFF_8001);

        // Randomized transactions against the reference model.
        for (int n = 0; n < 300; n++) begin
            int          op;
            int          wc;
            logic [31:0] ra;
            op = int'($urandom % 3);
            ra = $urandom;
            if ($urandom % 2 == 0) ra = ra & 32'hFFFF_FFFC;
            wc = ($urandom % 16 == 0) ? TIMEOUT + 3 : int'($urandom % 4);
            access(op != 1, op != 0, 3'($urandom % 8), ra, $urandom, $urandom, wc);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-stage block directly downstream of the core datapath.
- Consumes the datapath's effective address (alu_res), store data (write_data) and funct3 (f3), and runs a valid/ready word-bus transaction to data memory.
- Returns the formatted load value on read_data back into the datapath's writeback mux.
- Stalls the datapath while the access is in flight; flags misaligned/illegal accesses and bus timeouts.

Parameters:
- AW, 14, word-address width (16-bit byte space, matching the 16-bit pc)
- TIMEOUT, 15, max ACCESS cycles waiting for bus_ready before fault (>=1)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous reset, active low
- req_rd  in  1  load request from control (held until stall=0)
- req_wr  in  1  store request from control (held until stall=0)
- f3  in  3  funct3 of the load/store instruction
- addr  in  32  byte address (datapath alu_res)
- wdata  in  32  store data (datapath write_data)
- read_data  out  32  formatted load result to datapath
- stall  out  1  freeze pc/regfile while high
- misalign  out  1  one-cycle pulse: misaligned or illegal f3, no bus access
- bus_fault  out  1  one-cycle pulse: bus timeout
- bus_valid  out  1  bus request valid
- bus_we  out  1  1 = write
- bus_addr  out  AW  word address = addr[AW+1:2]
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-aligned store data
- bus_ready  in  1  bus accepts/completes transfer
- bus_rdata  in  32  read word, valid when bus_valid&bus_ready

Behaviour:
- Reset (async, rst_n=0): state IDLE; read_data=0; all bus_* outputs, stall, misalign, bus_fault = 0; timeout counter = 0. Asserting reset during ACCESS drops bus_valid immediately; the transfer is abandoned.
- FSM states: IDLE, ACCESS, DONE, ERR.
- IDLE, req=req_rd|req_wr:
  - req with legal, aligned access -> stall=1 combinationally this cycle; go ACCESS.
  - req with illegal or misaligned access -> misalign=1 this cycle, stall=0, no bus access; stay IDLE.
  - req_rd and req_wr both high -> treated as a store.
- Legal f3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Other f3 on a load is illegal.
  - Stores: 000 SB, 001 SH, 010 SW. Other f3 on a store is illegal.
- Alignment: halfword requires addr[0]=0; word requires addr[1:0]=00.
- ACCESS:
  - bus_valid=1; bus_addr, bus_we, bus_be, bus_wdata stable until bus_ready; stall=1.
  - Counter increments each cycle without bus_ready.
  - bus_ready=1 -> load captures formatted bus_rdata into read_data; go DONE.
  - Counter reaches TIMEOUT -> go ERR; bus_valid drops on entering ERR.
- DONE: stall=0, bus_valid=0; the datapath advances this cycle; -> IDLE. The request still held in DONE never re-triggers.
- ERR: bus_fault=1, stall=0, read_data<=0 (loads only); -> IDLE.
- Latency: request in cycle N, bus_ready in N+1 -> DONE in N+2 (stall high for 2 cycles); each extra wait cycle adds 1.
- Byte enables and store data:
  - Loads: bus_be=1111, bus_we=0.
  - SB: be=0001<<addr[1:0]; wdata[7:0] replicated on all 4 lanes.
  - SH: be=0011<<(2*addr[1]); wdata[15:0] replicated on both halves.
  - SW: be=1111; wdata as is.
- Load format: select byte lane addr[1:0] or half lane addr[1]. LB/LH sign-extend to 32 bits; LBU/LHU zero-extend; LW passes the word.
- read_data holds its last load value across stores, faults, misaligns and idle cycles.
- bus_ready while not in ACCESS is ignored.

Test Plan:
- LW addr=0x0010, bus_ready one cycle after valid, bus_rdata=0xDEADBEEF -> bus_addr=0x0004, be=1111, stall high 2 cycles, read_data=0xDEADBEEF in DONE.
- LB addr=0x0013, rdata=0x80FFFFFF -> read_data=0xFFFFFF80. LBU same -> 0x00000080. LHU addr=0x0012, rdata=0xBEEF1234 -> 0x0000BEEF.
- SB addr=0x0021 wdata=0x000000AB -> bus_we=1, be=0010, bus_wdata=0xABABABAB; SH addr=0x0022 wdata=0x1234 -> be=1100, bus_wdata=0x12341234; read_data unchanged.
- LH addr=0x0011, then SW addr=0x0022, then load f3=011 -> misalign pulses 1 cycle each, bus_valid stays 0, stall=0.
- LW with bus_ready held low -> bus_valid high for exactly TIMEOUT=15 cycles, then bus_fault pulse, read_data=0, return to IDLE; a following load completes normally.
- rst_n low for 1 cycle mid-ACCESS -> bus_valid/stall drop asynchronously, read_data=0, next request accepted from IDLE.
